rr_hold_arbiter: RTL and testbench
==================================

// Module: rr_hold_arbiter
// PURPOSE
//   Parametrised N-port arbiter, successor to the fixed-priority day14 arbiter.
//   Adds a run-time fixed/round-robin mode and grant hold (lock) until the owner releases.
//   Adds a MAX_HOLD timeout so no single port can starve the others.
//   Sits in front of a shared resource; requesters keep req high for the whole transaction.
// PARAMETERS
//   NUM_PORTS  4   number of requesters (>=2)
//   MAX_HOLD   8   max consecutive grant cycles per owner; 0 = no limit
//   ID_W       $clog2(NUM_PORTS)  width of grant index (derived, do not override)
// PORTS
//   clk          in   1          rising-edge clock
//   rst          in   1          asynchronous, active-high reset
//   req_i        in   NUM_PORTS  request vector, bit i = port i
//   mode_i       in   1          0 = fixed priority (port 0 highest), 1 = round-robin
//   gnt_o        out  NUM_PORTS  registered one-hot grant (all-zero when idle)
//   gnt_valid_o  out  1          |gnt_o
//   gnt_id_o     out  ID_W       index of granted port (0 when idle)
//   timeout_o    out  1          1-cycle pulse: current grant ended by MAX_HOLD expiry
// BEHAVIOUR
//   Reset (async): gnt_o=0, gnt_valid_o=0, gnt_id_o=0, timeout_o=0, ptr=0, hold_cnt=0, state=IDLE.
//   FSM states: IDLE (no owner) and OWNED (one port holds the grant).
//   Arbitration (combinational pick, registered result):
//     fixed: lowest-index requester wins.
//     RR: first requester at or after ptr, searching upward with wrap N-1 -> 0.
//   IDLE: any req_i bit set in cycle T -> gnt_o one-hot at T+1, state OWNED, hold_cnt=1.
//     No request -> stay IDLE; outputs remain 0.
//   On every new grant to port k: ptr <= (k+1) mod NUM_PORTS.
//     ptr updates in both modes; it is only used in RR mode.
//   OWNED, owner k:
//     req_i[k]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD) -> keep grant; hold_cnt++, saturating.
//     req_i[k]=0 (release) -> re-arbitrate among req_i in the same cycle, with no idle gap:
//       winner -> new one-hot grant next cycle; none -> IDLE next cycle with gnt_o=0.
//     hold_cnt==MAX_HOLD while req_i[k]=1 (timeout) -> timeout_o=1 for 1 cycle.
//       Then re-arbitrate with the owner's request masked out for that one decision.
//       No other requester -> owner is re-granted and hold_cnt=1.
//   Grant changes only on owner release, timeout, or reset.
//     A new higher-priority request never preempts the current owner.
//   mode_i is sampled only at arbitration points; a change during OWNED has no effect until then.
//   Changes to non-owner req_i bits during OWNED are ignored until the next arbitration.
//   Invariant: gnt_o is one-hot or zero in every cycle; gnt_id_o matches gnt_o.
//   Reset asserted mid-grant: all outputs clear immediately (asynchronously); ptr returns to 0.
// TESTING
//   1 rst, then req_i=4'b0110, mode=0 -> gnt_o=4'b0010 one cycle later, gnt_id_o=1, gnt_valid_o=1.
//   2 mode=1, req_i=4'b1111 held; each owner drops req 2 cycles after its grant
//     -> grant order 0,1,2,3,0 (wrap), no idle cycles between grants.
//   3 MAX_HOLD=8, req_i=4'b0011 held, mode=1 -> port0 granted 8 cycles, then timeout_o pulse,
//     then port1 granted 8 cycles, then port0 again.
//   4 only port2 requests, held 20 cycles, MAX_HOLD=8 -> timeout_o every 8 cycles;
//     gnt_o stays 4'b0100 throughout.
//   5 port3 owns the grant; req_i[0] rises -> no preemption. Port3 releases with mode=0
//     -> gnt_o=4'b0001 on the next cycle.
//   6 rst pulse mid-grant -> gnt_o=0 with no clock edge required; next req_i=4'b1000 in RR
//     mode -> port3 granted (search from ptr=0), ptr becomes 0.

Source files
------------

// File: rtl/rr_hold_arbiter.sv
// N-port arbiter with run-time fixed/round-robin selection, grant hold until the
// owner releases, and a MAX_HOLD limit so one owner cannot starve the rest.
module rr_hold_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 mode_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 timeout_o
);

  // With MAX_HOLD == 0 the counter only needs to saturate, one bit is enough.
  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HC_MAX   = '1;
  localparam logic [HC_W-1:0] HC_LIMIT = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HC_ONE   = HC_W'(1);

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [NUM_PORTS-1:0]  r_gnt;
  logic [NUM_PORTS-1:0]  w_gnt_next;
  logic [ID_W-1:0]       r_gnt_id;
  logic [ID_W-1:0]       w_id_next;
  logic                  r_timeout;
  logic                  w_timeout_next;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       w_ptr_next;
  logic [HC_W-1:0]       r_hold_cnt;
  logic [HC_W-1:0]       w_hold_next;
  logic                  w_grant_next;
  logic                  w_arbitrate;
  logic [NUM_PORTS-1:0]  w_arb_vec;
  logic [NUM_PORTS-1:0]  w_others;
  logic                  w_owner_req;
  logic                  w_at_limit;

  // Fixed: lowest index wins. RR: first requester at or after ptr, wrapping.
  function automatic logic [ID_W-1:0] pick(
    input logic [NUM_PORTS-1:0] vec,
    input logic                 rr,
    input logic [ID_W-1:0]      ptr
  );
    logic [ID_W-1:0]      id;
    logic                 found;
    logic [NUM_PORTS-1:0] shifted;
    int                   idx;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx     = rr ? ((int'(ptr) + i) % NUM_PORTS) : i;
      shifted = vec >> idx;
      if (!found && shifted[0]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
    return id;
  endfunction

  assign w_owner_req = |(req_i & r_gnt);
  assign w_others    = req_i & ~r_gnt;
  assign w_at_limit  = (MAX_HOLD != 0) && (r_hold_cnt >= HC_LIMIT);

  always_comb begin
    w_state_next   = r_state;
    w_id_next      = r_gnt_id;
    w_grant_next   = (r_state == S_OWNED);
    w_timeout_next = 1'b0;
    w_ptr_next     = r_ptr;
    w_hold_next    = r_hold_cnt;
    w_arbitrate    = 1'b0;
    w_arb_vec      = '0;

    case (r_state)
      S_IDLE: begin
        if (|req_i) begin
          w_arbitrate = 1'b1;
          w_arb_vec   = req_i;
        end else begin
          w_grant_next = 1'b0;
          w_id_next    = '0;
        end
      end
      S_OWNED: begin
        if (w_owner_req && !w_at_limit) begin
          if (r_hold_cnt != HC_MAX) begin
            w_hold_next = r_hold_cnt + HC_ONE;
          end
        end else if (!w_owner_req) begin
          if (|req_i) begin
            w_arbitrate = 1'b1;
            w_arb_vec   = req_i;
          end else begin
            w_state_next = S_IDLE;
            w_grant_next = 1'b0;
            w_id_next    = '0;
            w_hold_next  = '0;
          end
        end else begin
          // Timeout: owner is excluded once; if nobody else wants it, it is re-granted.
          w_timeout_next = 1'b1;
          w_arbitrate    = 1'b1;
          w_arb_vec      = (|w_others) ? w_others : r_gnt;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = 1'b0;
        w_id_next    = '0;
      end
    endcase

    if (w_arbitrate) begin
      w_id_next    = pick(w_arb_vec, mode_i, r_ptr);
      w_state_next = S_OWNED;
      w_grant_next = 1'b1;
      w_hold_next  = HC_ONE;
      w_ptr_next   = ID_W'((int'(w_id_next) + 1) % NUM_PORTS);
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
    assign w_gnt_next[gi] = w_grant_next && (w_id_next == ID_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_timeout  <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_gnt      <= w_gnt_next;
      r_gnt_id   <= w_id_next;
      r_timeout  <= w_timeout_next;
      r_ptr      <= w_ptr_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = |r_gnt;
  assign gnt_id_o    = r_gnt_id;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed-vector bench for rr_hold_arbiter (NUM_PORTS=4, MAX_HOLD=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_rr_hold_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       mode_i;
  logic [3:0] gnt_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_id_o;
  logic       timeout_o;

  int n_total = 0;
  int n_pass  = 0;

  rr_hold_arbiter #(
    .NUM_PORTS (4),
    .MAX_HOLD  (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .mode_i      (mode_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_id_o    (gnt_id_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Checks the full output bundle against an expected one-hot grant and timeout.
  task automatic check_gnt(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
    logic [1:0] exp_id;
    exp_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) exp_id = 2'(i);
    end
    check({tag, "_gnt"},   32'(gnt_o),       32'(exp_gnt));
    check({tag, "_valid"}, 32'(gnt_valid_o), 32'(|exp_gnt));
    check({tag, "_id"},    32'(gnt_id_o),    32'(exp_id));
    check({tag, "_to"},    32'(timeout_o),   32'(exp_to));
    $display("[%0t] %s req=%b mode=%b gnt=%b id=%0d to=%b", $time, tag, req_i, mode_i,
             gnt_o, gnt_id_o, timeout_o);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    int         p;

    rst    = 1'b1;
    req_i  = 4'b0000;
    mode_i = 1'b0;
    @(negedge clk);
    check_gnt("reset", 4'b0000, 1'b0);
    rst = 1'b0;

    // 1: fixed priority, lowest index wins
    req_i = 4'b0110;
    @(negedge clk);
    check_gnt("fixed_first", 4'b0010, 1'b0);
    req_i = 4'b0000;
    @(negedge clk);
    check_gnt("release_idle", 4'b0000, 1'b0);

    // 2: round-robin rotation with no idle gap between owners
    do_reset();
    mode_i = 1'b1;
    req_i  = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      p     = order[k];
      exp_g = 4'b0001 << p;
      check_gnt("rr_grant", exp_g, 1'b0);
      @(negedge clk);
      check_gnt("rr_hold", exp_g, 1'b0);
      req_i[p] = 1'b0;
      @(negedge clk);
      req_i[p] = 1'b1;
    end

    // 3: MAX_HOLD timeout hands grant over and back
    do_reset();
    mode_i = 1'b1;
    req_i  = 4'b0011;
    for (int t = 1; t <= 17; t++) begin
      @(negedge clk);
      exp_g = (t <= 8 || t == 17) ? 4'b0001 : 4'b0010;
      check_gnt("timeout_pair", exp_g, (t == 9 || t == 17));
    end

    // 4: sole requester is re-granted after each timeout
    do_reset();
    req_i = 4'b0100;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      check_gnt("timeout_solo", 4'b0100, (t == 9 || t == 17));
    end

    // 5: no preemption, then fixed-priority handover on release
    do_reset();
    mode_i = 1'b0;
    req_i  = 4'b1000;
    @(negedge clk);
    check_gnt("own_p3", 4'b1000, 1'b0);
    req_i = 4'b1001;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check_gnt("no_preempt", 4'b1000, 1'b0);
    end
    req_i = 4'b0001;
    @(negedge clk);
    check_gnt("handover_p0", 4'b0001, 1'b0);

    // 6: asynchronous reset mid-grant, then RR search restarts from port 0
    mode_i = 1'b1;
    req_i  = 4'b0100;
    @(negedge clk);
    check_gnt("pre_rst_p2", 4'b0100, 1'b0);
    #2 rst = 1'b1;
    #1 check_gnt("async_rst", 4'b0000, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    req_i = 4'b1000;
    @(negedge clk);
    check_gnt("post_rst_p3", 4'b1000, 1'b0);
    req_i = 4'b0110;
    @(negedge clk);
    check_gnt("ptr_wrap_p1", 4'b0010, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
